pc_fetch_ctrl: RTL and testbench

Consumes the jump, branch and trap target addresses produced upstream and owns the architectural program counter. Selects the next PC and issues instruction fetches to instruction memory over a request/acknowledge/valid handshake. Holds the fetched instruction for the decode/control FSM. A redirect while a fetch is in flight squashes the stale instruction. Misaligned targets are flagged instead of being taken.

---
 rtl/pc_fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the architectural PC, picks the next PC from the
// upstream jump/branch/trap targets and fetches the instruction at PC over
// a req/ack/valid handshake. The fetched word is held in IR for decode.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), async active-high reset
//   pc_write_i          one-cycle strobe: advance/redirect PC
//   pc_source_i[2:0]    0 PC+4, 1 JALR, 2 BRANCH, 3 JAL, 4 MTVEC, 5 MEPC, 6/7 PC+4
//   jal_i, branch_i, jalr_i, mtvec_i, mepc_i   candidate targets
//   fetch_req_o, fetch_addr_o                  request to instruction memory
//   fetch_ack_i, fetch_valid_i, fetch_data_i   memory accept / response
//   pc_o, pc_plus4_o    current PC and PC+4 (link value)
//   ir_o, ir_valid_o    latched instruction, valid for the current PC
//   misalign_o          one-cycle pulse on a misaligned PC_WRITE target
//   busy_o              high unless an instruction is held
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pc_write_i,
  input  logic [2:0]  pc_source_i,
  input  logic [31:0] jal_i,
  input  logic [31:0] branch_i,
  input  logic [31:0] jalr_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        fetch_req_o,
  output logic [31:0] fetch_addr_o,
  input  logic        fetch_ack_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] ir_o,
  output logic        ir_valid_o,
  output logic        misalign_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_HAVE} state_t;

  state_t      state_q;
  logic [31:0] pc_q, ir_q, npc_d, pc_plus4;
  logic        ir_valid_q, misalign_q, bad_tgt;

  assign pc_plus4 = pc_q + 32'd4;  // 32-bit modulo, wraps at top of space

  always_comb begin
    npc_d = pc_plus4;
    case (pc_source_i)
      3'd1:    npc_d = jalr_i;
      3'd2:    npc_d = branch_i;
      3'd3:    npc_d = jal_i;
      3'd4:    npc_d = mtvec_i;
      3'd5:    npc_d = mepc_i;
      default: npc_d = pc_plus4;
    endcase
  end

  // A misaligned target is reported and otherwise ignored; it wins over
  // every redirect/handshake action in the FSM below.
  assign bad_tgt = pc_write_i && (npc_d[1:0] != 2'b00);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_VECTOR;
      ir_q       <= 32'h0;
      ir_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      if (bad_tgt) begin
        misalign_q <= 1'b1;
      end else begin
        case (state_q)
          S_REQ: begin
            // Unacked request may simply be retargeted; an acked one
            // leaves a response in flight that must be drained.
            if (pc_write_i) begin
              pc_q <= npc_d;
              if (fetch_ack_i) state_q <= S_DRAIN;
            end else if (fetch_ack_i) begin
              state_q <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (pc_write_i) begin
              pc_q    <= npc_d;
              state_q <= fetch_valid_i ? S_REQ : S_DRAIN;
            end else if (fetch_valid_i) begin
              ir_q       <= fetch_data_i;
              ir_valid_q <= 1'b1;
              state_q    <= S_HAVE;
            end
          end
          S_DRAIN: begin
            if (pc_write_i) pc_q <= npc_d;
            if (fetch_valid_i) state_q <= S_REQ;  // stale word dropped
          end
          S_HAVE: begin
            if (pc_write_i) begin
              pc_q       <= npc_d;
              ir_valid_q <= 1'b0;
              state_q    <= S_REQ;
            end
          end
          default: state_q <= S_REQ;
        endcase
      end
    end
  end

  assign fetch_req_o  = (state_q == S_REQ);
  assign fetch_addr_o = pc_q;
  assign pc_o         = pc_q;
  assign pc_plus4_o   = pc_plus4;
  assign ir_o         = ir_q;
  assign ir_valid_o   = ir_valid_q;
  assign misalign_o   = misalign_q;
  assign busy_o       = (state_q != S_HAVE);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        pc_write = 1'b0;
  logic [2:0]  pc_source = 3'd0;
  logic [31:0] jal = 0, branch = 0, jalr = 0, mtvec = 0, mepc = 0;
  logic        fetch_req, fetch_ack = 1'b0, fetch_valid = 1'b0;
  logic [31:0] fetch_addr, fetch_data = 0;
  logic [31:0] pc, pc_plus4, ir;
  logic        ir_valid, misalign, busy;

  int errors = 0;
  int checks = 0;

  pc_fetch_ctrl #(.RESET_VECTOR(32'h0000_0100)) dut (
    .clk_i(clk), .rst_i(rst), .pc_write_i(pc_write), .pc_source_i(pc_source),
    .jal_i(jal), .branch_i(branch), .jalr_i(jalr), .mtvec_i(mtvec), .mepc_i(mepc),
    .fetch_req_o(fetch_req), .fetch_addr_o(fetch_addr), .fetch_ack_i(fetch_ack),
    .fetch_valid_i(fetch_valid), .fetch_data_i(fetch_data),
    .pc_o(pc), .pc_plus4_o(pc_plus4), .ir_o(ir), .ir_valid_o(ir_valid),
    .misalign_o(misalign), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs and samples happen 1ns after the edge
  task automatic step();
    @(posedge clk); #1;
  endtask

  // zero-wait fetch starting in REQ: ack this cycle, data next cycle
  task automatic fetch0(input logic [31:0] word);
    fetch_ack = 1'b1; step(); fetch_ack = 1'b0;
    fetch_valid = 1'b1; fetch_data = word; step(); fetch_valid = 1'b0;
  endtask

  task automatic write_pc(input logic [2:0] src);
    pc_source = src; pc_write = 1'b1; step(); pc_write = 1'b0;
  endtask

  initial begin
    // ---- reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h100);
    check("rst_ir", ir, 32'h0);
    check("rst_irv", {31'h0, ir_valid}, 32'h0);
    check("rst_mis", {31'h0, misalign}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    step();
    check("first_req", {31'h0, fetch_req}, 32'h1);
    check("first_addr", fetch_addr, 32'h100);
    fetch_ack = 1'b1; step(); fetch_ack = 1'b0;
    check("wait_noreq", {31'h0, fetch_req}, 32'h0);
    check("wait_irv", {31'h0, ir_valid}, 32'h0);
    fetch_valid = 1'b1; fetch_data = 32'h13; step(); fetch_valid = 1'b0;
    check("have_irv", {31'h0, ir_valid}, 32'h1);
    check("have_ir", ir, 32'h13);
    check("have_busy", {31'h0, busy}, 32'h0);

    // ---- sequential PC+4 three times
    for (int i = 1; i <= 3; i++) begin
      write_pc(3'd0);
      check("seq_pc", pc, 32'h100 + 32'(4 * i));
      check("seq_addr", fetch_addr, 32'h100 + 32'(4 * i));
      check("seq_req", {31'h0, fetch_req}, 32'h1);
      check("seq_irv_low", {31'h0, ir_valid}, 32'h0);
      check("seq_plus4", pc_plus4, 32'h104 + 32'(4 * i));
      fetch0(32'h1000 + 32'(i));
      check("seq_ir", ir, 32'h1000 + 32'(i));
    end

    // ---- redirect from HAVE at 0x200 to branch 0x1F0
    jal = 32'h200; write_pc(3'd3); fetch0(32'h0000_0200);
    check("jal_pc", pc, 32'h200);
    branch = 32'h1F0; write_pc(3'd2);
    check("br_pc", pc, 32'h1F0);
    check("br_addr", fetch_addr, 32'h1F0);
    check("br_irv", {31'h0, ir_valid}, 32'h0);
    fetch_ack = 1'b1; step(); fetch_ack = 1'b0;
    check("br_wait_irv", {31'h0, ir_valid}, 32'h0);
    fetch_valid = 1'b1; fetch_data = 32'hAA; step(); fetch_valid = 1'b0;
    check("br_ir", ir, 32'hAA);
    check("br_irv_hi", {31'h0, ir_valid}, 32'h1);

    // ---- flush: JAL during WAIT, stale word dropped in DRAIN
    write_pc(3'd0);                      // -> 0x1F4, REQ
    fetch_ack = 1'b1; step(); fetch_ack = 1'b0;   // WAIT
    jal = 32'h400; write_pc(3'd3);       // DRAIN
    check("fl_pc", pc, 32'h400);
    check("fl_req", {31'h0, fetch_req}, 32'h0);
    check("fl_busy", {31'h0, busy}, 32'h1);
    step(); step();
    check("fl_irv", {31'h0, ir_valid}, 32'h0);
    check("fl_req2", {31'h0, fetch_req}, 32'h0);
    fetch_valid = 1'b1; fetch_data = 32'hDEAD_BEEF; step(); fetch_valid = 1'b0;
    check("fl_newreq", {31'h0, fetch_req}, 32'h1);
    check("fl_newaddr", fetch_addr, 32'h400);
    check("fl_irv2", {31'h0, ir_valid}, 32'h0);
    fetch0(32'h0040_0093);
    check("fl_ir", ir, 32'h0040_0093);

    // ---- misaligned JALR in HAVE
    jalr = 32'h302; write_pc(3'd1);
    check("mis_pulse", {31'h0, misalign}, 32'h1);
    check("mis_pc", pc, 32'h400);
    check("mis_ir", ir, 32'h0040_0093);
    check("mis_irv", {31'h0, ir_valid}, 32'h1);
    step();
    check("mis_end", {31'h0, misalign}, 32'h0);
    check("mis_busy", {31'h0, busy}, 32'h0);

    // ---- MTVEC retarget while unacked in REQ, then MEPC and source 6
    mepc = 32'h80; write_pc(3'd5);
    check("mepc_pc", pc, 32'h80);
    mtvec = 32'h40; write_pc(3'd4);      // REQ, no ack: retarget
    check("mtvec_req", {31'h0, fetch_req}, 32'h1);
    check("mtvec_addr", fetch_addr, 32'h40);
    fetch0(32'h55);
    write_pc(3'd6);
    check("src6_pc", pc, 32'h44);
    fetch0(32'h66);

    // ---- wrap, then reset during WAIT
    jal = 32'hFFFF_FFFC; write_pc(3'd3);
    check("wrap_plus4", pc_plus4, 32'h0);
    fetch0(32'h77);
    write_pc(3'd0);
    check("wrap_pc", pc, 32'h0);
    fetch_ack = 1'b1; step(); fetch_ack = 1'b0;   // WAIT
    rst = 1'b1; #1;
    check("mrst_pc", pc, 32'h100);
    check("mrst_irv", {31'h0, ir_valid}, 32'h0);
    check("mrst_ir", ir, 32'h0);
    step();
    rst = 1'b0;
    fetch_valid = 1'b1; fetch_data = 32'hBAD0_BAD0; step(); fetch_valid = 1'b0;
    check("late_req", {31'h0, fetch_req}, 32'h1);
    check("late_irv", {31'h0, ir_valid}, 32'h0);
    check("late_addr", fetch_addr, 32'h100);
    fetch0(32'h13);
    check("post_ir", ir, 32'h13);
    check("post_irv", {31'h0, ir_valid}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
